// File: rtl/mips_pc_pkg.sv
// Shared definitions for the fetch-stage program-counter logic:
// next-PC source encodings and the instruction word width.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JREG   = 2'b11
    } pc_src_e;

    localparam int INSTR_W = 32;

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch-control bundle between the decode/branch logic (master) and the
// program-counter unit (slave).
interface next_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic                     en;
    logic [1:0]               pc_src;
    logic signed [ADDR_W-1:0] sign_imm;
    logic [25:0]              jump_idx;
    logic [ADDR_W-1:0]        reg_target;
    logic                     call;
    logic                     ret;
    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        pc_plus4;
    logic                     ras_empty;
    logic                     ras_ovf;
    logic                     ras_unf;
    logic                     misalign;

    modport master (
        output en, pc_src, sign_imm, jump_idx, reg_target, call, ret,
        input  pc, pc_plus4, ras_empty, ras_ovf, ras_unf, misalign
    );

    modport slave (
        input  en, pc_src, sign_imm, jump_idx, reg_target, call, ret,
        output pc, pc_plus4, ras_empty, ras_ovf, ras_unf, misalign
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop leaves state alone. ovf/unf are single-cycle event pulses.
module return_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              stall,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr_q, top_ptr_d, wr_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_en, pop_en, do_pop, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign top   = mem_q[top_ptr_q];

    always_comb begin
        push_en   = push && !stall;
        pop_en    = pop && !stall;
        do_pop    = pop_en && !empty;
        unf       = pop_en && empty;
        ovf       = push_en && full && !do_pop;
        wr_en     = push_en;
        wr_ptr    = top_ptr_q + PTR_W'(1);
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        // Pop-then-push replaces the top in place; pointer and count stay put.
        if (do_pop && push_en) begin
            wr_ptr = top_ptr_q;
        end else if (do_pop) begin
            top_ptr_d = top_ptr_q - PTR_W'(1);
            count_d   = count_q - CNT_W'(1);
        end else if (push_en) begin
            top_ptr_d = wr_ptr;
            if (!full) count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch program counter: picks the next address from sequential, branch,
// jump, register or return-stack sources and folds it into program space.
module next_pc_unit
    import mips_pc_pkg::*;
#(
    parameter int                  ADDR_W         = 32,
    parameter int                  PROG_ADDR_BITS = 8,
    parameter int                  RAS_DEPTH      = 4,
    parameter logic [ADDR_W-1:0]   RESET_ADDR     = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    next_pc_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_MASK =
        ADDR_W'((64'd1 << PROG_ADDR_BITS) - 64'd1) & ~ADDR_W'(3);

    function automatic logic [ADDR_W-1:0] condition_addr(input logic [ADDR_W-1:0] a);
        return a & PC_MASK;
    endfunction

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     misalign_q, misalign_d;
    logic                     ras_ovf_q, ras_ovf_d;
    logic                     ras_unf_q, ras_unf_d;
    logic [ADDR_W-1:0]        pc_plus4;
    logic signed [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0]        target;
    logic [ADDR_W-1:0]        ras_top;
    logic                     ras_empty, ras_full_unused, ras_ovf_pulse, ras_unf_pulse;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.call),
        .pop       (bus.ret),
        .stall     (!bus.en),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused),
        .ovf       (ras_ovf_pulse),
        .unf       (ras_unf_pulse)
    );

    always_comb begin
        branch_off = bus.sign_imm <<< 2;
        target     = pc_plus4;
        // A return overrides pc_src; an empty stack falls back to pc+4.
        if (bus.ret) begin
            target = ras_empty ? pc_plus4 : ras_top;
        end else begin
            case (pc_src_e'(bus.pc_src))
                PC_SEQ:    target = pc_plus4;
                PC_BRANCH: target = pc_plus4 + $unsigned(branch_off);
                PC_JUMP:   target = {pc_plus4[ADDR_W-1:28], bus.jump_idx, 2'b00};
                PC_JREG:   target = bus.reg_target;
                default:   target = pc_plus4;
            endcase
        end

        pc_d       = bus.en ? condition_addr(target) : pc_q;
        misalign_d = bus.en && (target[1:0] != 2'b00);
        ras_ovf_d  = ras_ovf_q | ras_ovf_pulse;
        ras_unf_d  = ras_unf_q | ras_unf_pulse;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_ADDR;
            misalign_q <= 1'b0;
            ras_ovf_q  <= 1'b0;
            ras_unf_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ras_ovf_q  <= ras_ovf_d;
            ras_unf_q  <= ras_unf_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_ovf   = ras_ovf_q;
    assign bus.ras_unf   = ras_unf_q;
    assign bus.misalign  = misalign_q;

endmodule
